// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// Optional build macro used by this slice: SEQ_MULT_ZERO_BYPASS_EN.
package seq_mult_pkg;

   localparam int unsigned DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mult_state_t;

endpackage

// File: rtl/seq_mult_shift_add_if.sv
// Operand/result handshake bundle for seq_mult_shift_add.
// master drives operands and out_ready; slave is the multiplier.
interface seq_mult_shift_add_if
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );

endinterface

// File: rtl/seq_mult_shift_add_fa_4bit.sv
// Ripple-carry adder, generalised to WIDTH bits; one full-adder cell per bit.
module fa_4bit #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   logic [WIDTH:0] carry;

   // Carry ripples from bit 0 upward through the full-adder chain.
   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = c_in;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      c_out = carry[WIDTH];
   end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential unsigned shift-and-add multiplier: one adder pass per cycle,
// 2*WIDTH-bit product after WIDTH iterations, valid/ready on both sides.
// Build option: SEQ_MULT_ZERO_BYPASS_EN skips the iterations for zero operands.
module seq_mult_shift_add
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   seq_mult_shift_add_if.slave bus
);

   localparam int unsigned     CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   mult_state_t        state;
   mult_state_t        state_next;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH:0]   acc;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               cout;
   logic               accept;
   logic               zero_op;

   assign accept = bus.in_valid && (state == IDLE);

`ifdef SEQ_MULT_ZERO_BYPASS_EN
   assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
   assign zero_op = 1'b0;
`endif

   // Upper half of acc plus the multiplicand when the current multiplier bit is set.
   assign addend = acc[0] ? mcand : '0;

   fa_4bit #(
      .WIDTH (WIDTH)
   ) u_add (
      .a     (acc[2*WIDTH-1:WIDTH]),
      .b     (addend),
      .c_in  (1'b0),
      .sum   (sum),
      .c_out (cout)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic: accept in IDLE, iterate in BUSY, hold in DONE until taken.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = zero_op ? DONE : BUSY;
         BUSY:    if (cnt == CNT_LAST) state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: load operands on accept, add-and-shift right once per BUSY cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  mcand <= bus.a;
                  acc   <= zero_op ? '0 : {1'b0, {WIDTH{1'b0}}, bus.b};
                  cnt   <= '0;
               end
            end
            BUSY: begin
               acc <= {1'b0, cout, sum, acc[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state == BUSY);
   assign bus.out_valid = (state == DONE);
   assign bus.product   = acc[2*WIDTH-1:0];

   // The product always fits in 2*WIDTH bits, so the guard bit is clear once done.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      (state == DONE) |-> !acc[2*WIDTH]);

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Testbench for seq_mult_shift_add: vector table, scoreboard queue,
// and hand-written back-to-back and mid-operation reset sequences.
module tb_seq_mult_shift_add;

   localparam int unsigned W = 4;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      int unsigned    hold;
      logic [2*W-1:0] exp;
   } vec_t;

   logic clk;
   logic rst_n;

   seq_mult_shift_add_if #(.WIDTH(W)) bus ();

   seq_mult_shift_add #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned    checks;
   int unsigned    passes;
   int unsigned    cycle;
   logic [2*W-1:0] exp_q [$];
   logic           last_acc;
   logic           last_out;
   vec_t           vecs [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // One clock: record handshakes seen before the edge, then update the scoreboard.
   task automatic step();
      logic           acc_fire;
      logic           out_fire;
      logic [2*W-1:0] prod_seen;
      logic [2*W-1:0] exp_p;
      acc_fire  = bus.in_valid && bus.in_ready;
      out_fire  = bus.out_valid && bus.out_ready;
      prod_seen = bus.product;
      exp_p     = {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};
      @(posedge clk);
      #1;
      cycle++;
      last_acc = acc_fire;
      last_out = out_fire;
      if (acc_fire) exp_q.push_back(exp_p);
      if (out_fire) begin
         check("sb_has_entry", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("sb_product", prod_seen, exp_q.pop_front());
      end
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input int unsigned hold, input logic [2*W-1:0] exp_p);
      int unsigned    lat;
      int unsigned    exp_lat;
      logic           seen_busy;
      logic           exp_busy;
      logic           stable;
      logic [2*W-1:0] p0;
      exp_lat  = W;
      exp_busy = 1'b1;
`ifdef SEQ_MULT_ZERO_BYPASS_EN
      if (ta == '0 || tb_v == '0) begin
         exp_lat  = 0;
         exp_busy = 1'b0;
      end
`endif
      bus.a         = ta;
      bus.b         = tb_v;
      bus.in_valid  = 1'b1;
      bus.out_ready = (hold == 0);
      check("in_ready_idle", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      check("accepted", last_acc, 1);
      check("in_ready_drop", bus.in_ready, 0);
      lat       = 0;
      seen_busy = bus.busy;
      while (!bus.out_valid && lat < 40) begin
         step();
         lat++;
         seen_busy |= bus.busy;
      end
      check("latency", lat, exp_lat);
      check("busy_seen", seen_busy, exp_busy);
      check("product_done", bus.product, exp_p);
      p0     = bus.product;
      stable = 1'b1;
      for (int unsigned i = 0; i < hold; i++) begin
         step();
         if (bus.product !== p0 || bus.out_valid !== 1'b1 || last_out) stable = 1'b0;
      end
      if (hold > 0) check("hold_stable", stable, 1);
      bus.out_ready = 1'b1;
      step();
      check("out_fired", last_out, 1);
      check("out_valid_drop", bus.out_valid, 0);
      check("in_ready_back", bus.in_ready, 1);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int unsigned n_acc;
      int unsigned n_out;
      int unsigned first_acc;
      int unsigned second_acc;

      vecs[0] = '{a: 4'd3,  b: 4'd5,  hold: 0,  exp: 8'd15};
      vecs[1] = '{a: 4'd15, b: 4'd15, hold: 0,  exp: 8'd225};
      vecs[2] = '{a: 4'd9,  b: 4'd6,  hold: 10, exp: 8'd54};
      vecs[3] = '{a: 4'd0,  b: 4'd12, hold: 0,  exp: 8'd0};
      vecs[4] = '{a: 4'd12, b: 4'd0,  hold: 0,  exp: 8'd0};
      vecs[5] = '{a: 4'd1,  b: 4'd1,  hold: 0,  exp: 8'd1};
      vecs[6] = '{a: 4'd15, b: 4'd1,  hold: 3,  exp: 8'd15};
      vecs[7] = '{a: 4'd7,  b: 4'd9,  hold: 2,  exp: 8'd63};

      checks        = 0;
      passes        = 0;
      cycle         = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;

      #12;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_product", bus.product, 0);
      rst_n = 1'b1;
      step();

      for (int unsigned i = 0; i < 8; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].exp);

      // Requests held valid back to back: second one only enters after IDLE.
      n_acc         = 0;
      n_out         = 0;
      first_acc     = 0;
      second_acc    = 0;
      bus.out_ready = 1'b1;
      bus.a         = 4'd2;
      bus.b         = 4'd7;
      bus.in_valid  = 1'b1;
      for (int unsigned i = 0; i < 40 && n_out < 2; i++) begin
         step();
         if (last_acc) begin
            n_acc++;
            if (n_acc == 1) begin
               first_acc = cycle;
               bus.a     = 4'd4;
               bus.b     = 4'd4;
            end else begin
               second_acc   = cycle;
               bus.in_valid = 1'b0;
            end
         end
         if (last_out) n_out++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("b2b_accepts", n_acc, 2);
      check("b2b_outputs", n_out, 2);
      check("b2b_gap", second_acc - first_acc, W + 2);
      check("b2b_sb_empty", exp_q.size(), 0);
      step();

      // Asynchronous reset two cycles into BUSY.
      bus.a         = 4'd11;
      bus.b         = 4'd13;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      check("rst_mid_busy", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", bus.out_valid, 0);
      check("rst_mid_product", bus.product, 0);
      check("rst_mid_in_ready", bus.in_ready, 1);
      check("rst_mid_busy_low", bus.busy, 0);
      exp_q.delete();
      #4 rst_n = 1'b1;
      run_op(4'd11, 4'd13, 0, 8'd143);
      check("final_sb_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/seq_mult_shift_add.md
Name: seq_mult_shift_add

Overview:
Sequential unsigned shift-and-add multiplier. It consumes the sum and carry-out of a WIDTH-bit ripple-carry adder once per cycle and produces a 2*WIDTH-bit product after WIDTH iterations. Valid/ready handshake on both sides lets it sit between an operand source and a result sink in the arithmetic datapath. One operation in flight at a time; no pipelining.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits; legal range 2..16

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  multiplicand, unsigned
b  input  WIDTH  multiplier, unsigned
out_valid  output  1  product valid, held until accepted
out_ready  input  1  sink accepts product
product  output  2*WIDTH  a*b, unsigned
busy  output  1  high in BUSY state

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous and active-low. Asserting rst_n low forces the block to IDLE immediately, at any time, including mid-operation or while out_valid is high.
- Reset values: state=IDLE, mcand=0, acc=0 (2*WIDTH+1 bits), cnt=0, out_valid=0, busy=0, product=0. in_ready=1 when out of reset.
- in_ready is (state==IDLE). busy is (state==BUSY). out_valid is (state==DONE). product is acc[2*WIDTH-1:0], registered.
- IDLE:
  - On in_valid && in_ready at a clock edge, load mcand<=a, acc<={1'b0, WIDTH'b0, b}, cnt<=0, and go to BUSY.
  - Operands not accepted are ignored; there is no buffering.
- BUSY, each edge:
  - Form {cout, sum} = acc[2W-1:W] + (acc[0] ? mcand : 0) with carry-in 0, using a (WIDTH+1)-bit result.
  - Update acc <= {1'b0, cout, sum, acc[W-1:1]}, a logical right shift by 1.
  - cnt <= cnt+1. When cnt==WIDTH-1 at this edge, go to DONE.
  - a, b and in_valid are ignored while in BUSY.
- Latency: operands accepted on edge E. The last iteration executes on edge E+WIDTH, and out_valid is high from edge E+WIDTH. For WIDTH=4 that is 4 cycles.
- DONE:
  - product is stable and out_valid=1.
  - On out_ready high at an edge, go to IDLE. in_ready rises the following cycle.
  - With out_ready low, the block holds indefinitely and product does not change.
  - in_valid high while in DONE is not accepted, even when out_ready is high on the same edge. There is no back-to-back overlap.
- Arithmetic: the full product always fits in 2*WIDTH bits; the carry-out at acc[2W] is 0 at completion. Max case: (2^W-1)^2, which is 225 for W=4.
- cnt width is $clog2(WIDTH)+1. cnt never wraps because the state exits at WIDTH-1.

Optional Feature:
Macro: SEQ_MULT_ZERO_BYPASS_EN
- Defined: at accept, if a==0 or b==0, go directly IDLE->DONE with acc=0. out_valid is high after 1 edge, and BUSY is skipped (busy stays 0).
- Not defined: zero operands take the full WIDTH iterations like any other operands.
- The handshake and product value are identical in both builds.

Decomposition:
- Package seq_mult_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t.
  - Constant DEF_WIDTH=4.
- One natural sub-module: the existing ripple adder fa_4bit, generalised through its WIDTH parameter and instantiated once.
  - Connections: a=acc[2W-1:W], b=masked mcand, c_in=0.
  - Its sum and c_out feed the shift register.
- FSM, counter and acc register live in seq_mult_shift_add.

Test Plan:
- Reset then a=3, b=5, in_valid for 1 cycle, out_ready=1 -> in_ready drops next cycle; out_valid high exactly 4 cycles after accept; product=15; in_ready back after the handshake.
- a=15, b=15 -> product=225; out_valid high for exactly 1 cycle with out_ready=1.
- a=9, b=6, out_ready=0 for 10 cycles then 1 -> product=54 stable throughout; out_valid stays high; returns to IDLE on the out_ready edge.
- Back-to-back requests (in_valid held high with a=2,b=7 then a=4,b=4) -> second request accepted only after IDLE; products 14 then 16; no request lost or duplicated.
- Assert rst_n low at cycle 2 of BUSY (a=11, b=13) -> out_valid=0, product=0, in_ready=1 immediately; a fresh a=11, b=13 then yields 143.
- a=0, b=12 -> product=0. With SEQ_MULT_ZERO_BYPASS_EN: out_valid after 1 cycle, busy never high. Without the macro: after 4 cycles.
